// File: rtl/ppu_interrupt_multi_if.sv
// ppu_interrupt_multi_if
//   Bundle of the PPU timing inputs, host-side controls and interrupt status
//   of ppu_interrupt_multi. Clock and reset stay plain ports on the block.
//   slave  : the interrupt block (samples sig/mode/clears, drives status)
//   master : the host / timing source side
//   Signals:
//     sig_i        [NUM_CH]            asynchronous source levels
//     mode_i       [2*NUM_CH]          per-channel edge mode (00 off, 01 rise, 10 fall, 11 both)
//     clear_mask_i [NUM_CH]            per-channel clear strobe
//     clear_all_i                      clear every channel
//     pending_o    [NUM_CH]            sticky pending bits
//     overrun_o    [NUM_CH]            sticky overrun bits
//     count_o      [NUM_CH*CNT_WIDTH]  saturating event counts
//     irq_o, irq_pulse_o               interrupt level and rising-edge pulse
//     first_valid_o, first_idx_o       only when PPU_INT_FIRST_EN is defined
interface ppu_interrupt_multi_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8
);
    logic [NUM_CH-1:0]           sig_i;
    logic [2*NUM_CH-1:0]         mode_i;
    logic [NUM_CH-1:0]           clear_mask_i;
    logic                        clear_all_i;
    logic [NUM_CH-1:0]           pending_o;
    logic [NUM_CH-1:0]           overrun_o;
    logic [NUM_CH*CNT_WIDTH-1:0] count_o;
    logic                        irq_o;
    logic                        irq_pulse_o;

`ifdef PPU_INT_FIRST_EN
    localparam int IDX_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    logic             first_valid_o;
    logic [IDX_W-1:0] first_idx_o;

    modport slave (
        input  sig_i, mode_i, clear_mask_i, clear_all_i,
        output pending_o, overrun_o, count_o, irq_o, irq_pulse_o,
        output first_valid_o, first_idx_o
    );
    modport master (
        output sig_i, mode_i, clear_mask_i, clear_all_i,
        input  pending_o, overrun_o, count_o, irq_o, irq_pulse_o,
        input  first_valid_o, first_idx_o
    );
`else
    modport slave (
        input  sig_i, mode_i, clear_mask_i, clear_all_i,
        output pending_o, overrun_o, count_o, irq_o, irq_pulse_o
    );
    modport master (
        output sig_i, mode_i, clear_mask_i, clear_all_i,
        input  pending_o, overrun_o, count_o, irq_o, irq_pulse_o
    );
`endif
endinterface

// File: rtl/ppu_interrupt_multi.sv
// ppu_interrupt_multi
//   Multi-channel PPU edge interrupt block. Each of NUM_CH asynchronous
//   timing inputs goes through a SYNC_STAGES-deep synchroniser plus one
//   history flop; edges between the last sync stage and the history flop are
//   qualified by a per-channel mode and latched into sticky pending bits,
//   overrun bits and saturating event counters. irq_o is the OR of pending,
//   irq_pulse_o flags its 0->1 transition one cycle later.
//   Ports:
//     clock  system clock
//     reset  asynchronous active-low reset
//     bus    ppu_interrupt_multi_if.slave (sig/mode/clear in, status out)
//   Optional build macro PPU_INT_FIRST_EN adds first_valid_o / first_idx_o:
//   capture of the lowest channel index of the first event since the last
//   clear_all_i.

// One channel: synchroniser, edge qualification, pending/overrun/counter.
module ppu_interrupt_multi_ch #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_WIDTH   = 8,
    parameter logic INIT        = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sig,
    input  logic [1:0]           mode,
    input  logic                 clr,
    output logic                 pend_nxt,
    output logic                 pending,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] count
`ifdef PPU_INT_FIRST_EN
    ,
    output logic                 ev
`endif
);
`ifndef PPU_INT_FIRST_EN
    logic ev;
`endif
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   ovr_nxt;
    logic [CNT_WIDTH-1:0]   cnt_nxt;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~hist_q;
    assign fall = ~s & hist_q;
    // mode[0] enables rising, mode[1] falling; 11 therefore means both.
    assign ev   = (mode[0] & rise) | (mode[1] & fall);

    // A new event always wins over a clear in the same cycle.
    assign pend_nxt = ev | (pending & ~clr);
    assign ovr_nxt  = (ev & pending & ~clr) | (overrun & ~clr);

    always_comb begin
        cnt_nxt = count;
        if (clr)
            cnt_nxt = ev ? CNT_WIDTH'(1) : '0;
        else if (ev && (count != '1))
            cnt_nxt = count + CNT_WIDTH'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= {SYNC_STAGES{INIT}};
            hist_q  <= INIT;
            pending <= 1'b0;
            overrun <= 1'b0;
            count   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig};
            hist_q  <= s;
            pending <= pend_nxt;
            overrun <= ovr_nxt;
            count   <= cnt_nxt;
        end
    end
endmodule

module ppu_interrupt_multi #(
    parameter int                NUM_CH      = 4,
    parameter int                SYNC_STAGES = 2,
    parameter int                CNT_WIDTH   = 8,
    parameter logic [NUM_CH-1:0] INIT_LEVEL  = NUM_CH'(4'b0011)
) (
    input  logic                   clock,
    input  logic                   reset,
    ppu_interrupt_multi_if.slave   bus
);
    logic [NUM_CH-1:0]                pend_nxt;
    logic [NUM_CH-1:0]                pending;
    logic [NUM_CH-1:0]                overrun;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_arr;
    logic [NUM_CH-1:0]                clr;
    logic                             irq_q;
    logic                             irq_prev_q;
    logic                             irq_pulse_q;

`ifdef PPU_INT_FIRST_EN
    localparam int IDX_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    logic [NUM_CH-1:0] ev;
`endif

    assign clr = bus.clear_mask_i | {NUM_CH{bus.clear_all_i}};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ppu_interrupt_multi_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_WIDTH   (CNT_WIDTH),
            .INIT        (INIT_LEVEL[i])
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .sig      (bus.sig_i[i]),
            .mode     (bus.mode_i[2*i +: 2]),
            .clr      (clr[i]),
            .pend_nxt (pend_nxt[i]),
            .pending  (pending[i]),
            .overrun  (overrun[i]),
            .count    (cnt_arr[i])
`ifdef PPU_INT_FIRST_EN
            ,
            .ev       (ev[i])
`endif
        );
    end

    // irq tracks next-state pending so it moves on the same edge as pending_o.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_q       <= 1'b0;
            irq_prev_q  <= 1'b0;
            irq_pulse_q <= 1'b0;
        end else begin
            irq_q       <= |pend_nxt;
            irq_prev_q  <= irq_q;
            irq_pulse_q <= irq_q & ~irq_prev_q;
        end
    end

    assign bus.pending_o   = pending;
    assign bus.overrun_o   = overrun;
    assign bus.count_o     = cnt_arr;
    assign bus.irq_o       = irq_q;
    assign bus.irq_pulse_o = irq_pulse_q;

`ifdef PPU_INT_FIRST_EN
    logic             first_valid_q;
    logic [IDX_W-1:0] first_idx_q;
    logic [IDX_W-1:0] low_idx;

    // Scan downwards so the lowest active channel is the last one written.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (ev[i]) low_idx = IDX_W'(i);
    end

    // clear_all_i re-arms the capture; an event in that same cycle recaptures.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
        end else if ((|ev) && (!first_valid_q || bus.clear_all_i)) begin
            first_valid_q <= 1'b1;
            first_idx_q   <= low_idx;
        end else if (bus.clear_all_i) begin
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
        end
    end

    assign bus.first_valid_o = first_valid_q;
    assign bus.first_idx_o   = first_idx_q;
`endif
endmodule
